// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event port carrying the serialized edge events.
// The arbiter drives it as master and the event consumer uses it as slave.
interface edge_event_arbiter_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic            evtValid;
    logic            evtReady;
    logic [CH_W-1:0] evtChannel;
    logic            evtRising;

    modport master (output evtValid, output evtChannel, output evtRising, input evtReady);
    modport slave  (input evtValid, input evtChannel, input evtRising, output evtReady);
endinterface

// File: rtl/edge_event_arbiter.sv
// Filters per-channel edge pulses into one-entry pending slots and serializes them
// round-robin onto a registered valid/ready event port, counting dropped events.
module edge_event_slot (
    input  logic       clock,
    input  logic       reset,
    input  logic       rise_i,
    input  logic       fall_i,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    input  logic       grant_i,
    output logic       pend_o,
    output logic       rise_o,
    output logic [1:0] drop_o
);
    logic qual_r, qual_f, evt, busy;
    logic pend_q, rise_q;

    assign qual_r = en_i & rise_i & mode_i[0];
    assign qual_f = en_i & fall_i & mode_i[1];
    assign evt    = qual_r | qual_f;
    // A slot being granted this cycle is free for a new event.
    assign busy   = pend_q & ~grant_i;

    // Both edges at once: rising takes the slot, falling is always dropped.
    always_comb begin
        drop_o = 2'd0;
        if (qual_r & qual_f)
            drop_o = busy ? 2'd2 : 2'd1;
        else if (evt & busy)
            drop_o = 2'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
            rise_q <= 1'b0;
        end else if (!en_i) begin
            pend_q <= 1'b0;
        end else if (evt & ~busy) begin
            pend_q <= 1'b1;
            rise_q <= qual_r;
        end else if (grant_i) begin
            pend_q <= 1'b0;
        end
    end

    assign pend_o = pend_q;
    assign rise_o = rise_q;
endmodule

module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     risingEdge,
    input  logic [NUM_CH-1:0]     fallingEdge,
    input  logic [NUM_CH-1:0]     chEnable,
    input  logic [2*NUM_CH-1:0]   edgeMode,
    edge_event_arbiter_if.master  evt,
    output logic [NUM_CH-1:0]     pending,
    output logic [CNT_W-1:0]      overflowCount
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int DSUM_W = $clog2(2*NUM_CH+1);
    localparam int SUM_W  = CNT_W + DSUM_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH-1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                   state_q;
    logic                     valid_q, erise_q;
    logic [CH_W-1:0]          ech_q, rr_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_CH-1:0]        rise_slot, req, grant;
    logic [NUM_CH-1:0][1:0]   drop;
    logic [CH_W-1:0]          gidx;
    logic                     gfound, do_grant;
    logic [DSUM_W-1:0]        drops;
    logic [SUM_W-1:0]         sum;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        edge_event_slot u_slot (
            .clock   (clock),
            .reset   (reset),
            .rise_i  (risingEdge[i]),
            .fall_i  (fallingEdge[i]),
            .en_i    (chEnable[i]),
            .mode_i  (edgeMode[2*i+1:2*i]),
            .grant_i (grant[i]),
            .pend_o  (pending[i]),
            .rise_o  (rise_slot[i]),
            .drop_o  (drop[i])
        );
    end

    assign req = pending & chEnable;

    // Scan downward so the last hit written is the nearest channel at or after rr_q.
    always_comb begin
        logic [CH_W-1:0] idx;
        gidx   = '0;
        gfound = 1'b0;
        idx    = '0;
        for (int k = NUM_CH-1; k >= 0; k--) begin
            idx = CH_W'((int'(rr_q) + k) % NUM_CH);
            if (req[idx]) begin
                gidx   = idx;
                gfound = 1'b1;
            end
        end
    end

    assign do_grant = gfound & ((state_q == IDLE) | evt.evtReady);
    assign grant    = do_grant ? (NUM_CH'(1) << gidx) : '0;

    always_comb begin
        drops = '0;
        for (int i = 0; i < NUM_CH; i++)
            drops = drops + DSUM_W'(drop[i]);
        sum   = SUM_W'(cnt_q) + SUM_W'(drops);
        cnt_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ech_q   <= '0;
            erise_q <= 1'b0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                IDLE, HOLD: begin
                    if (do_grant) begin
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                        ech_q   <= gidx;
                        erise_q <= rise_slot[gidx];
                        rr_q    <= (gidx == LAST_CH) ? '0 : gidx + 1'b1;
                    end else if (state_q == HOLD && evt.evtReady) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign evt.evtValid   = valid_q;
    assign evt.evtChannel = ech_q;
    assign evt.evtRising  = erise_q;
    assign overflowCount  = cnt_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench: expected events go into a scoreboard queue, a negedge monitor
// pops and compares on every handshake; state checks are made inline.
module tb_edge_event_arbiter;
    logic       clock, reset;
    logic [3:0] rise, fall, en, pend;
    logic [7:0] mode, ovf;
    logic       rdy;
    logic [3:0] rise2, fall2, en2, pend2;
    logic [7:0] mode2;
    logic [1:0] ovf2;
    logic       rdy2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct { int ch; int rise; int cyc; } exp_t;
    exp_t exp_q[$];

    edge_event_arbiter_if #(.NUM_CH(4)) ev ();
    edge_event_arbiter_if #(.NUM_CH(4)) ev2 ();
    assign ev.evtReady  = rdy;
    assign ev2.evtReady = rdy2;

    edge_event_arbiter #(.NUM_CH(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .risingEdge(rise), .fallingEdge(fall),
        .chEnable(en), .edgeMode(mode), .evt(ev), .pending(pend), .overflowCount(ovf));

    edge_event_arbiter #(.NUM_CH(4), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .risingEdge(rise2), .fallingEdge(fall2),
        .chEnable(en2), .edgeMode(mode2), .evt(ev2), .pending(pend2), .overflowCount(ovf2));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input int r, input int c);
        exp_t e;
        e.ch = ch; e.rise = r; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset && ev.evtValid && ev.evtReady) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got ch=%0d rise=%0d at cycle %0d, expected none",
                         ev.evtChannel, ev.evtRising, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(ev.evtChannel) != e.ch || int'(ev.evtRising) != e.rise ||
                    (e.cyc >= 0 && cyc != e.cyc)) begin
                    miscompares++;
                    $display("FAIL event: got ch=%0d rise=%0d cycle=%0d, expected ch=%0d rise=%0d cycle=%0d",
                             ev.evtChannel, ev.evtRising, cyc, e.ch, e.rise, e.cyc);
                end
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1; rise = '0; fall = '0; en = '0; mode = '0; rdy = 1'b0;
        rise2 = '0; fall2 = '0; en2 = '0; mode2 = '0; rdy2 = 1'b0;
        #2;
        check("rst_valid", ev.evtValid, 0);
        check("rst_channel", ev.evtChannel, 0);
        check("rst_rising", ev.evtRising, 0);
        check("rst_pending", pend, 0);
        check("rst_overflow", ovf, 0);
        tick(1);
        reset = 1'b0;

        // single event, latency 2
        en = 4'b0100; mode = 8'b00_01_00_00; rdy = 1'b1;
        tick(1);
        push(2, 1, cyc + 2);
        rise = 4'b0100;
        tick(1);
        rise = '0;
        check("single_pend_t1", pend[2], 1);
        check("single_valid_t1", ev.evtValid, 0);
        tick(5);

        // round-robin from a fresh pointer
        do_reset();
        en = 4'b1011; mode = 8'hFF; rdy = 1'b1;
        t = cyc;
        push(0, 1, t + 2); push(1, 1, t + 3); push(3, 1, t + 4);
        rise = 4'b1011;
        tick(1); rise = '0; tick(4);
        push(1, 1, cyc + 2);
        rise = 4'b0010;
        tick(1); rise = '0; tick(3);
        // pointer now sits at 2, so ch3 outranks ch0
        push(3, 1, cyc + 2); push(0, 1, cyc + 3);
        rise = 4'b1001;
        tick(1); rise = '0; tick(4);

        // backpressure and overflow
        rdy = 1'b0;
        rise = 4'b0010; tick(1);
        rise = '0;      tick(1);
        check("bp_valid_hold", ev.evtValid, 1);
        check("bp_channel", ev.evtChannel, 1);
        rise = 4'b0010; tick(1);
        rise = '0;
        check("bp_pending1", pend[1], 1);
        tick(1);
        rise = 4'b0010; tick(1);
        rise = '0;
        check("bp_overflow", ovf, 1);
        push(1, 1, cyc); push(1, 1, cyc + 1);
        rdy = 1'b1;
        tick(3);
        check("bp_overflow_stays", ovf, 1);
        check("bp_pending_drained", pend, 0);

        // mode filter: ch0 accepts falling only
        en = 4'b0001; mode = 8'b11_11_11_10; rdy = 1'b1;
        rise = 4'b0001; tick(1); rise = '0;
        check("mode_rise_filtered", pend[0], 0);
        tick(4);
        push(0, 0, cyc + 2);
        fall = 4'b0001; tick(1); fall = '0; tick(4);

        // enable low clears a pending slot, held output survives
        rdy = 1'b0;
        fall = 4'b0001; tick(1); fall = '0; tick(1);
        fall = 4'b0001; tick(1); fall = '0;
        check("en_pending_set", pend[0], 1);
        en = 4'b0000; tick(1);
        check("en_pending_cleared", pend[0], 0);
        en = 4'b0001; tick(1);
        check("en_no_reload", pend, 0);
        push(0, 0, cyc);
        rdy = 1'b1;
        tick(4);

        // saturation with a 2-bit counter
        en2 = 4'b0001; mode2 = 8'hFF; rdy2 = 1'b0;
        rise2 = 4'b0001; tick(1); rise2 = '0; tick(2);
        check("sat_valid_held", ev2.evtValid, 1);
        check("sat_channel", ev2.evtChannel, 0);
        check("sat_rising", ev2.evtRising, 1);
        rise2 = 4'b0001; tick(1); rise2 = '0; tick(1);
        check("sat_pending", pend2, 1);
        for (int i = 0; i < 6; i++) begin
            rise2 = 4'b0001; tick(1); rise2 = '0; tick(1);
            if (i == 1) check("sat_two_drops", ovf2, 2);
        end
        check("sat_count", ovf2, 3);
        tick(3);
        check("sat_count_stays", ovf2, 3);
        rise2 = 4'b0001; fall2 = 4'b0001; tick(1); rise2 = '0; fall2 = '0; tick(1);
        check("sat_count_double_drop", ovf2, 3);

        // reset mid-operation
        do_reset();
        en = 4'b1111; mode = 8'hFF; rdy = 1'b0;
        rise = 4'b0001; tick(1); rise = '0; tick(2);
        rise = 4'b1011; tick(1); rise = '0; tick(1);
        rise = 4'b0011; fall = 4'b0011; tick(1);
        rise = 4'b1000; fall = '0;      tick(1);
        rise = '0; tick(1);
        check("pre_rst_overflow", ovf, 5);
        check("pre_rst_pending", pend, 4'b1011);
        check("pre_rst_valid", ev.evtValid, 1);
        #2;
        reset = 1'b1;
        rise = 4'b0100;
        #1;
        check("async_rst_valid", ev.evtValid, 0);
        check("async_rst_channel", ev.evtChannel, 0);
        check("async_rst_rising", ev.evtRising, 0);
        check("async_rst_pending", pend, 0);
        check("async_rst_overflow", ovf, 0);
        tick(1);
        rise = '0;
        tick(1);
        reset = 1'b0;
        rdy = 1'b1;
        check("rst_ignored_pulse", pend, 0);
        push(0, 1, cyc + 2); push(3, 1, cyc + 3);
        rise = 4'b1001;
        tick(1); rise = '0; tick(5);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
